// File: rtl/misr_bus_router.sv
// Routes core memory requests to the data SRAM or to one of N_MISR MISR CSR banks.
// Define MISR_ACCESS_CNT_EN to add per-channel saturating access counters (access_cnt_o).
module misr_bus_router #(
    parameter int unsigned NBIT_AXI_WIDTH         = 64,
    parameter int unsigned USER_AXI_WIDTH         = 10,
    parameter int unsigned NBIT_MISR_DATA         = 64,
    parameter int unsigned N_MISR                 = 4,
    parameter int unsigned N_MISR_CSR             = 3,
    parameter logic [63:0] MISR_PERIPH_START_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned CNT_W                  = 16,
    localparam int unsigned CH_W  = (N_MISR > 1) ? $clog2(N_MISR) : 1,
    localparam int unsigned CSR_W = (N_MISR_CSR > 1) ? $clog2(N_MISR_CSR) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             request_i,
    output logic                             gnt_o,
    input  logic                             wr_en_i,
    input  logic [NBIT_AXI_WIDTH/8-1:0]      byte_en_i,
    input  logic [NBIT_AXI_WIDTH-1:0]        address_i,
    input  logic [NBIT_AXI_WIDTH-1:0]        data_i,
    input  logic [USER_AXI_WIDTH-1:0]        user_i,
    output logic                             rvalid_o,
    output logic [NBIT_AXI_WIDTH-1:0]        rdata_o,
    output logic                             rerr_o,
    output logic                             req_o,
    input  logic                             gnt_i,
    output logic                             we_o,
    output logic [NBIT_AXI_WIDTH/8-1:0]      be_o,
    output logic [NBIT_AXI_WIDTH-1:0]        addr_o,
    output logic [NBIT_AXI_WIDTH-1:0]        data_o,
    output logic [USER_AXI_WIDTH-1:0]        user_o,
    input  logic                             rvalid_i,
    input  logic [NBIT_AXI_WIDTH-1:0]        rdata_i,
    output logic [N_MISR-1:0]                re_misr_o,
    output logic [N_MISR-1:0]                we_misr_o,
    output logic [CSR_W-1:0]                 csr_idx_o,
    output logic [NBIT_MISR_DATA-1:0]        data_misr_o,
    input  logic [N_MISR*NBIT_MISR_DATA-1:0] rdata_misr_i
`ifdef MISR_ACCESS_CNT_EN
    ,
    output logic [N_MISR*CNT_W-1:0]          access_cnt_o
`endif
);

    localparam logic [NBIT_AXI_WIDTH-1:0] START  = NBIT_AXI_WIDTH'(MISR_PERIPH_START_ADDR);
    localparam logic [NBIT_AXI_WIDTH-1:0] STRIDE = NBIT_AXI_WIDTH'(NBIT_MISR_DATA / 8);
    localparam logic [NBIT_AXI_WIDTH-1:0] SPAN   = NBIT_AXI_WIDTH'(NBIT_MISR_DATA / 8 * N_MISR_CSR);
    localparam logic [NBIT_AXI_WIDTH-1:0] WIN    =
        NBIT_AXI_WIDTH'(NBIT_MISR_DATA / 8 * N_MISR_CSR * N_MISR);

    typedef enum logic [2:0] {StIdle, StSramWait, StMisrAcc, StMisrResp, StErrResp} state_e;

    state_e                      state_q;
    logic [CH_W-1:0]             ch_q;
    logic [CSR_W-1:0]            csr_q;
    logic                        we_q;
    logic [NBIT_MISR_DATA-1:0]   wdata_q;
    logic [NBIT_AXI_WIDTH-1:0]   rdata_q;

    logic [NBIT_AXI_WIDTH-1:0]   off;
    logic                        is_sram;
    logic                        is_misr;
    logic [CH_W-1:0]             dec_ch;
    logic [CSR_W-1:0]            dec_csr;
    logic [NBIT_MISR_DATA-1:0]   misr_rd [N_MISR];

    always_comb begin
        off     = address_i - START;
        is_sram = address_i < START;
        is_misr = !is_sram && (off < WIN) && ((off % STRIDE) == '0);
        dec_ch  = CH_W'(off / SPAN);
        dec_csr = CSR_W'((off % SPAN) / STRIDE);
    end

    always_comb begin
        for (int k = 0; k < int'(N_MISR); k++) begin
            misr_rd[k] = rdata_misr_i[k*NBIT_MISR_DATA +: NBIT_MISR_DATA];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ch_q    <= '0;
            csr_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (request_i) begin
                        if (is_sram) begin
                            if (gnt_i) state_q <= StSramWait;
                        end else if (is_misr) begin
                            state_q <= StMisrAcc;
                            ch_q    <= dec_ch;
                            csr_q   <= dec_csr;
                            we_q    <= wr_en_i;
                            wdata_q <= NBIT_MISR_DATA'(data_i);
                        end else begin
                            state_q <= StErrResp;
                        end
                    end
                end
                StSramWait: if (rvalid_i) state_q <= StIdle;
                StMisrAcc: begin
                    // Writes answer with zero data.
                    rdata_q <= we_q ? '0 : NBIT_AXI_WIDTH'(misr_rd[ch_q]);
                    state_q <= StMisrResp;
                end
                StMisrResp: state_q <= StIdle;
                StErrResp:  state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        gnt_o     = 1'b0;
        req_o     = 1'b0;
        rvalid_o  = 1'b0;
        rdata_o   = '0;
        rerr_o    = 1'b0;
        re_misr_o = '0;
        we_misr_o = '0;
        unique case (state_q)
            StIdle: begin
                req_o = request_i & is_sram;
                gnt_o = request_i & (is_sram ? gnt_i : 1'b1);
            end
            StSramWait: begin
                rvalid_o = rvalid_i;
                rdata_o  = rdata_i;
            end
            StMisrAcc: begin
                if (we_q) we_misr_o[ch_q] = 1'b1;
                else      re_misr_o[ch_q] = 1'b1;
            end
            StMisrResp: begin
                rvalid_o = 1'b1;
                rdata_o  = rdata_q;
            end
            StErrResp: begin
                rvalid_o = 1'b1;
                rerr_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign we_o        = wr_en_i;
    assign be_o        = byte_en_i;
    assign addr_o      = address_i;
    assign data_o      = data_i;
    assign user_o      = user_i;
    assign csr_idx_o   = csr_q;
    assign data_misr_o = wdata_q;

`ifdef MISR_ACCESS_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_MISR];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(N_MISR); k++) cnt_q[k] <= '0;
        end else if (state_q == StMisrAcc && cnt_q[ch_q] != '1) begin
            cnt_q[ch_q] <= cnt_q[ch_q] + CNT_W'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_MISR); k++) begin
            access_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`endif

endmodule
